load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Single-request load/store unit between the execute stage and a simple req/ack memory bus.
// Handles byte-lane steering, sign/zero extension, alignment faults and bus timeouts.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Memory-op codes shared with the decoder.
    localparam logic [5:0] ALU_LB  = 6'h10;
    localparam logic [5:0] ALU_LH  = 6'h11;
    localparam logic [5:0] ALU_LW  = 6'h12;
    localparam logic [5:0] ALU_LBU = 6'h13;
    localparam logic [5:0] ALU_LHU = 6'h14;
    localparam logic [5:0] ALU_SB  = 6'h18;
    localparam logic [5:0] ALU_SH  = 6'h19;
    localparam logic [5:0] ALU_SW  = 6'h1A;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

    state_t      state_reg, state_next;
    logic [5:0]  op_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [7:0]  cnt_reg;
    logic        err_timeout_reg;
    logic [31:0] rdata_reg;

    logic        op_valid;
    logic        op_fault;
    logic        accept;
    logic        expire;
    logic        is_store;
    logic [3:0]  be_val;
    logic [31:0] wdata_val;
    logic [31:0] lane;
    logic [31:0] load_ext;

    // Decode of the incoming request, evaluated only at latch time.
    always_comb begin
        op_valid = 1'b0;
        op_fault = 1'b0;
        case (alucode)
            ALU_LB, ALU_LBU, ALU_SB: op_valid = 1'b1;
            ALU_LH, ALU_LHU, ALU_SH: begin
                op_valid = 1'b1;
                op_fault = addr[0];
            end
            ALU_LW, ALU_SW: begin
                op_valid = 1'b1;
                op_fault = (addr[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    assign accept = (state_reg == IDLE) && start && op_valid;
    assign expire = (state_reg == WAIT) && !mem_ack && (cnt_reg == CNT_LAST);

    always_comb begin
        is_store  = 1'b0;
        be_val    = 4'b0000;
        wdata_val = 32'h0;
        case (op_reg)
            ALU_LB, ALU_LBU: be_val = 4'b0001 << addr_reg[1:0];
            ALU_LH, ALU_LHU: be_val = addr_reg[1] ? 4'b1100 : 4'b0011;
            ALU_LW:          be_val = 4'b1111;
            ALU_SB: begin
                is_store  = 1'b1;
                be_val    = 4'b0001 << addr_reg[1:0];
                wdata_val = {4{wdata_reg[7:0]}};
            end
            ALU_SH: begin
                is_store  = 1'b1;
                be_val    = addr_reg[1] ? 4'b1100 : 4'b0011;
                wdata_val = {2{wdata_reg[15:0]}};
            end
            ALU_SW: begin
                is_store  = 1'b1;
                be_val    = 4'b1111;
                wdata_val = wdata_reg;
            end
            default: ;
        endcase
    end

    // Requests are aligned, so shifting by the byte offset puts the addressed lane at bit 0.
    assign lane = mem_rdata >> {addr_reg[1:0], 3'b000};

    always_comb begin
        load_ext = 32'h0;
        case (op_reg)
            ALU_LB:  load_ext = {{24{lane[7]}}, lane[7:0]};
            ALU_LBU: load_ext = {24'h0, lane[7:0]};
            ALU_LH:  load_ext = {{16{lane[15]}}, lane[15:0]};
            ALU_LHU: load_ext = {16'h0, lane[15:0]};
            ALU_LW:  load_ext = mem_rdata;
            default: load_ext = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = op_fault ? ERR : WAIT;
            WAIT: begin
                if (mem_ack)     state_next = RESP;
                else if (expire) state_next = ERR;
            end
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg          <= 6'h0;
            addr_reg        <= 32'h0;
            wdata_reg       <= 32'h0;
            cnt_reg         <= 8'h0;
            err_timeout_reg <= 1'b0;
            rdata_reg       <= 32'h0;
        end else if (accept) begin
            op_reg          <= alucode;
            addr_reg        <= addr;
            wdata_reg       <= wdata;
            cnt_reg         <= 8'h0;
            err_timeout_reg <= 1'b0;
            if (op_fault) rdata_reg <= 32'h0;
        end else if (state_reg == WAIT) begin
            if (mem_ack) begin
                rdata_reg <= load_ext;
            end else if (expire) begin
                err_timeout_reg <= 1'b1;
                rdata_reg       <= 32'h0;
            end else begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    // Bus outputs are gated by WAIT so they read zero whenever no request is in flight.
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == RESP) || (state_reg == ERR);
    assign misalign  = (state_reg == ERR) && !err_timeout_reg;
    assign timeout   = (state_reg == ERR) && err_timeout_reg;
    assign rdata     = rdata_reg;
    assign mem_req   = (state_reg == WAIT);
    assign mem_we    = mem_req && is_store;
    assign mem_addr  = mem_req ? {addr_reg[31:2], 2'b00} : 32'h0;
    assign mem_be    = mem_req ? be_val : 4'b0000;
    assign mem_wdata = mem_req ? wdata_val : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed bus and result values per transaction.
// Inputs change #1 after the rising edge; outputs are checked there too (all outputs are registered).
module tb_load_store_unit;

    localparam logic [5:0] ALU_LB  = 6'h10;
    localparam logic [5:0] ALU_LH  = 6'h11;
    localparam logic [5:0] ALU_LW  = 6'h12;
    localparam logic [5:0] ALU_LBU = 6'h13;
    localparam logic [5:0] ALU_LHU = 6'h14;
    localparam logic [5:0] ALU_SB  = 6'h18;
    localparam logic [5:0] ALU_SH  = 6'h19;
    localparam logic [5:0] ALU_SW  = 6'h1A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  alucode = 6'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, misalign, timeout;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int n_compared = 0;
    int n_mismatched = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .alucode(alucode),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .misalign(misalign), .timeout(timeout), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then drop start; leaves the bench in the first post-start cycle.
    task automatic issue(input logic [5:0] code, input logic [31:0] a, input logic [31:0] d);
        start = 1'b1; alucode = code; addr = a; wdata = d;
        tick();
        start = 1'b0;
    endtask

    // Ack in the first WAIT cycle, then check the RESP cycle and the hold afterwards.
    task automatic ack_and_finish(input string tag, input logic [31:0] rd, input logic [31:0] exp_rdata);
        mem_ack = 1'b1; mem_rdata = rd;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check_value({tag, "_done"}, 32'(done), 32'd1);
        check_value({tag, "_rdata"}, rdata, exp_rdata);
        tick();
        check_value({tag, "_idle"}, 32'(busy), 32'd0);
        check_value({tag, "_hold"}, rdata, exp_rdata);
        $display("txn %s: rdata=0x%08h", tag, rdata);
    endtask

    initial begin
        int req_cycles;

        // Reset state
        #1;
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_req", 32'(mem_req), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_rdata", rdata, 32'h0);
        tick();
        rst = 1'b0;

        // Unknown code is ignored
        issue(6'h00, 32'h100, 32'h0);
        check_value("bad_code_busy", 32'(busy), 32'd0);
        $display("txn bad_code: ignored");

        // LW 0x100, ack in first WAIT cycle -> done two cycles after start
        issue(ALU_LW, 32'h100, 32'h0);
        check_value("lw_req", 32'(mem_req), 32'd1);
        check_value("lw_addr", mem_addr, 32'h100);
        check_value("lw_be", 32'(mem_be), 32'hF);
        check_value("lw_we", 32'(mem_we), 32'd0);
        ack_and_finish("lw", 32'hDEADBEEF, 32'hDEADBEEF);

        // LB / LBU at 0x103
        issue(ALU_LB, 32'h103, 32'h0);
        check_value("lb_be", 32'(mem_be), 32'h8);
        check_value("lb_addr", mem_addr, 32'h100);
        ack_and_finish("lb", 32'h80FF0000, 32'hFFFFFF80);
        issue(ALU_LBU, 32'h103, 32'h0);
        check_value("lbu_be", 32'(mem_be), 32'h8);
        ack_and_finish("lbu", 32'h80FF0000, 32'h00000080);

        // LH / LHU at 0x102 (upper half)
        issue(ALU_LH, 32'h102, 32'h0);
        check_value("lh_be", 32'(mem_be), 32'hC);
        ack_and_finish("lh", 32'h8001_1234, 32'hFFFF8001);
        issue(ALU_LHU, 32'h102, 32'h0);
        ack_and_finish("lhu", 32'h8001_1234, 32'h00008001);

        // SH 0x202, ack on third WAIT cycle; a start while busy must not disturb the request
        issue(ALU_SH, 32'h202, 32'h1234ABCD);
        for (int i = 0; i < 3; i++) begin
            check_value("sh_req", 32'(mem_req), 32'd1);
            check_value("sh_we", 32'(mem_we), 32'd1);
            check_value("sh_be", 32'(mem_be), 32'hC);
            check_value("sh_addr", mem_addr, 32'h200);
            check_value("sh_wdata", mem_wdata, 32'hABCDABCD);
            if (i == 0) begin
                start = 1'b1; alucode = ALU_LW; addr = 32'h500;
            end else begin
                start = 1'b0;
            end
            if (i == 2) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b1;  // stray ack in RESP must be ignored
        start = 1'b1; alucode = ALU_LW; addr = 32'h600;  // start in RESP ignored
        check_value("sh_done", 32'(done), 32'd1);
        check_value("sh_rdata", rdata, 32'h0);
        check_value("sh_req_drop", 32'(mem_req), 32'd0);
        tick();
        mem_ack = 1'b0; start = 1'b0;
        check_value("sh_idle", 32'(busy), 32'd0);
        check_value("sh_no_restart", 32'(mem_req), 32'd0);
        $display("txn sh: rdata=0x%08h", rdata);

        // Misaligned LW -> ERR next cycle, no bus request
        issue(ALU_LW, 32'h101, 32'h0);
        check_value("mis_req", 32'(mem_req), 32'd0);
        check_value("mis_done", 32'(done), 32'd1);
        check_value("mis_flag", 32'(misalign), 32'd1);
        check_value("mis_tmo", 32'(timeout), 32'd0);
        check_value("mis_rdata", rdata, 32'h0);
        tick();
        check_value("mis_idle", 32'(busy), 32'd0);
        $display("txn lw_misaligned: misalign=1");

        // SB at the same odd address proceeds
        issue(ALU_SB, 32'h101, 32'h00000055);
        check_value("sb_be", 32'(mem_be), 32'h2);
        check_value("sb_wdata", mem_wdata, 32'h55555555);
        check_value("sb_we", 32'(mem_we), 32'd1);
        ack_and_finish("sb", 32'hFFFFFFFF, 32'h0);

        // Load a nonzero value so the timeout rdata clear is visible
        issue(ALU_LW, 32'h104, 32'h0);
        ack_and_finish("lw_pre", 32'h13572468, 32'h13572468);

        // Timeout with TIMEOUT_CYCLES=4
        issue(ALU_LW, 32'h300, 32'h0);
        req_cycles = 0;
        while (mem_req && req_cycles < 10) begin
            req_cycles++;
            tick();
        end
        check_value("tmo_req_cycles", 32'(req_cycles), 32'd4);
        check_value("tmo_done", 32'(done), 32'd1);
        check_value("tmo_flag", 32'(timeout), 32'd1);
        check_value("tmo_mis", 32'(misalign), 32'd0);
        check_value("tmo_rdata", rdata, 32'h0);
        tick();
        check_value("tmo_idle", 32'(busy), 32'd0);
        $display("txn lw_timeout: req_cycles=%0d", req_cycles);

        // Reset pulsed mid-WAIT
        issue(ALU_LW, 32'h104, 32'h0);
        check_value("rw_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_value("rw_req_async", 32'(mem_req), 32'd0);
        check_value("rw_busy_async", 32'(busy), 32'd0);
        check_value("rw_rdata_async", rdata, 32'h0);
        tick();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        check_value("rw_late_ack", 32'(busy), 32'd0);
        check_value("rw_late_done", 32'(done), 32'd0);
        issue(ALU_SW, 32'h400, 32'hCAFEF00D);
        check_value("sw_be", 32'(mem_be), 32'hF);
        check_value("sw_wdata", mem_wdata, 32'hCAFEF00D);
        check_value("sw_addr", mem_addr, 32'h400);
        ack_and_finish("sw", 32'h0BADF00D, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        n_mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $fatal(1);
    end

endmodule
